reset_syncer: RTL and testbench

- Reset conditioning block: takes a raw active-low reset request and produces a clean, clock-aligned active-low reset for downstream logic in the same clock domain.
- Assertion is fast: one clock edge.
- Deassertion passes through a synchronizer chain and then a programmable hold-off counter, so the output releases only after the input has been stably high for a fixed number of edges.
- Instantiated once per clock domain, next to the clock source.

---
 rtl/reset_syncer.sv | 47 ++++
 tb/tb_reset_syncer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reset_syncer.sv
// reset_syncer: turns a raw active-low reset request into a clock-aligned reset
// that asserts in one edge and releases only after a synchronized, held-off high run.
module reset_syncer #(
    parameter int DLY         = 1,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_n_sync_i,
    output logic rst_n_synced_o
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    logic [SYNC_STAGES-1:0] chain;
    logic                   release_now;

    // Masking with the input (rather than branching) lets X on the input reach the state.
    always_ff @(posedge clk_i) begin
        chain <= #DLY {chain[SYNC_STAGES-2:0], 1'b1} & {SYNC_STAGES{rst_n_sync_i}};
    end

    if (HOLD_CYCLES == 0) begin : g_no_hold
        logic unused_top;
        assign unused_top  = chain[SYNC_STAGES-1];
        // The flop that would set the chain's top bit releases the output instead.
        assign release_now = chain[SYNC_STAGES-2];
    end else begin : g_hold
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk_i) begin
            if (!rst_n_sync_i) begin
                cnt <= #DLY '0;
            end else if (chain[SYNC_STAGES-1] && cnt != CNT_W'(HOLD_CYCLES)) begin
                cnt <= #DLY cnt + CNT_W'(1);
            end
        end

        // Release on the same edge that brings the count to HOLD_CYCLES.
        assign release_now = chain[SYNC_STAGES-1] && (cnt == CNT_W'(HOLD_CYCLES - 1));
    end

    always_ff @(posedge clk_i) begin
        rst_n_synced_o <= #DLY (rst_n_synced_o | release_now) & rst_n_sync_i;
    end

endmodule

// File: tb/tb_reset_syncer.sv
// tb_reset_syncer: three reset_syncer configurations on one shared input,
// checked every cycle against a count of consecutive high samples.
module tb_reset_syncer;

    logic clk = 1'b1;
    logic rst_n = 1'b1;
    logic o_def;
    logic o_s3;
    logic o_h255;

    int run = 0;
    int total = 0;
    int bad = 0;

    always #10 clk = ~clk;

    reset_syncer #(.DLY(1), .SYNC_STAGES(2), .HOLD_CYCLES(4)) u_def (
        .clk_i(clk),
        .rst_n_sync_i(rst_n),
        .rst_n_synced_o(o_def)
    );

    reset_syncer #(.DLY(1), .SYNC_STAGES(3), .HOLD_CYCLES(0)) u_s3 (
        .clk_i(clk),
        .rst_n_sync_i(rst_n),
        .rst_n_synced_o(o_s3)
    );

    reset_syncer #(.DLY(1), .SYNC_STAGES(2), .HOLD_CYCLES(255)) u_h255 (
        .clk_i(clk),
        .rst_n_sync_i(rst_n),
        .rst_n_synced_o(o_h255)
    );

    // Reference: output is high once the input has been sampled high on
    // SYNC_STAGES+HOLD_CYCLES consecutive edges; any low sample restarts.
    always @(posedge clk) begin
        if (rst_n !== 1'b1) run <= 0;
        else if (run < 100000) run <= run + 1;
    end

    function automatic logic [2:0] want();
        return {run >= 6, run >= 3, run >= 257};
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #201;
        rst_n = 1'b0;
        @(posedge clk);
        repeat (6) begin
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== 3'b000) begin
                bad++;
                $display("FAIL reset t=%0t got=%b want=000", $time, {o_def, o_s3, o_h255});
            end
        end
    endtask

    task automatic test_release();
        #12;
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL release t=%0t got=%b want=%b", $time, {o_def, o_s3, o_h255}, want());
            end
        end
    endtask

    task automatic test_abort();
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL abort_low t=%0t got=%b want=%b", $time, {o_def, o_s3, o_h255}, want());
            end
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL abort_rise t=%0t got=%b want=%b", $time, {o_def, o_s3, o_h255}, want());
            end
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL abort_cut t=%0t got=%b want=%b", $time, {o_def, o_s3, o_h255}, want());
            end
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL abort_restart t=%0t got=%b want=%b", $time, {o_def, o_s3, o_h255}, want());
            end
        end
    endtask

    task automatic test_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({o_def, o_s3} !== 2'b00) begin
            bad++;
            $display("FAIL pulse_assert t=%0t got=%b want=00", $time, {o_def, o_s3});
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL pulse_recover t=%0t got=%b want=%b", $time, {o_def, o_s3, o_h255}, want());
            end
        end
    endtask

    task automatic test_glitch();
        repeat (8) begin
            @(posedge clk);
            #3 rst_n = 1'b0;
            #2 rst_n = 1'b1;
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL glitch t=%0t got=%b want=%b", $time, {o_def, o_s3, o_h255}, want());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 11);
            rst_n = (r != 0);
            @(posedge clk);
            if (r == 1) begin
                #4 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL random i=%0d t=%0t got=%b want=%b", i, $time, {o_def, o_s3, o_h255}, want());
            end
        end
    endtask

    task automatic test_long();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1300) begin
            @(negedge clk);
            total++;
            if ({o_def, o_s3, o_h255} !== want()) begin
                bad++;
                $display("FAIL long t=%0t run=%0d got=%b want=%b", $time, run, {o_def, o_s3, o_h255}, want());
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_abort();
        test_pulse();
        test_glitch();
        test_random();
        test_long();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
